// File: rtl/ripple_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ripple_ext_pkg
// Description : Shared types and width helpers for the ripple count extender.
//               Holds the snapshot FSM encoding and the sizing functions.
//               Optional feature macro: RIPPLE_EXT_DELTA_EN (used by the top).
// Revision    : 1.0 - initial release
// ============================================================================
package ripple_ext_pkg;

    // Snapshot FSM states; the state register itself uses the localparam
    // copies below so it stays a plain explicit-width vector.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } snap_state_e;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_WAIT = WAIT;
    localparam logic [1:0] c_ST_HOLD = HOLD;

    // Width of the full snapshot: extension on top of the sampled bits.
    function automatic int total_width(input int in_w, input int ext_w);
        return in_w + ext_w;
    endfunction

    // Run counter must be able to hold the value STABLE_CYCLES itself.
    function automatic int run_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_count_extender_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer, synchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a cycle to resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ripple_count_extender.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_extender
// Description : Samples an asynchronous ripple counter, filters transients,
//               extends it with a wrap counter and returns snapshots over a
//               valid/ready handshake.
//               Optional feature macro: RIPPLE_EXT_DELTA_EN adds snap_delta,
//               the difference between consecutive snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_extender
    import ripple_ext_pkg::*;
#(
    parameter int IN_WIDTH      = 4,
    parameter int EXT_WIDTH     = 12,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           cnt_in,
    input  logic                          src_clear,
    input  logic                          snap_req,
    output logic                          snap_valid,
    input  logic                          snap_ready,
    output logic [IN_WIDTH+EXT_WIDTH-1:0] snap_count,
    output logic                          wrap_pulse,
    output logic                          ext_overflow
`ifdef RIPPLE_EXT_DELTA_EN
    ,
    output logic [IN_WIDTH+EXT_WIDTH-1:0] snap_delta
`endif
);

    localparam int c_TW = total_width(IN_WIDTH, EXT_WIDTH);
    localparam int c_RW = run_width(STABLE_CYCLES);
    localparam logic [c_RW-1:0] c_RUN_MAX = c_RW'(STABLE_CYCLES);

    logic [IN_WIDTH-1:0]  w_sync;
    logic [IN_WIDTH-1:0]  r_prev;
    logic [c_RW-1:0]      r_run;
    logic [IN_WIDTH-1:0]  r_stable;
    logic [EXT_WIDTH-1:0] r_ext;
    logic                 r_ovf;
    logic                 r_wrap;
    logic [c_ST_W-1:0]    r_state;
    logic [c_TW-1:0]      r_snap_count;
    logic                 r_snap_valid;

    logic [c_RW-1:0]      w_run_next;
    logic [IN_WIDTH-1:0]  w_stable_next;
    logic [EXT_WIDTH-1:0] w_ext_next;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_capture;
    logic [c_TW-1:0]      w_capture_value;

    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi = gi + 1) begin : g_sync
            sync_2ff u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (cnt_in[gi]),
                .q     (w_sync[gi])
            );
        end
    endgenerate

    // Run length of the current sample, acceptance, wrap and next state of
    // the tracked value; src_clear overrides everything else.
    always_comb begin
        if (w_sync != r_prev) begin
            w_run_next = c_RW'(1);
        end else if (r_run == c_RUN_MAX) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + c_RW'(1);
        end
        // Saturation makes "reached" equivalent to "equals the maximum".
        w_accept      = (w_run_next == c_RUN_MAX) && (w_sync != r_stable);
        w_wrap        = w_accept && (w_sync < r_stable);
        w_stable_next = w_accept ? w_sync : r_stable;
        w_ext_next    = r_ext + EXT_WIDTH'(w_wrap);
        if (src_clear) begin
            w_run_next    = '0;
            w_stable_next = '0;
            w_ext_next    = '0;
        end
        w_capture       = (r_state == c_ST_WAIT) && (w_run_next == c_RUN_MAX);
        w_capture_value = {w_ext_next, w_stable_next};
    end

    // Filter, stable value, extension counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= '0;
            r_run    <= '0;
            r_stable <= '0;
            r_ext    <= '0;
            r_wrap   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_prev   <= w_sync;
            r_run    <= w_run_next;
            r_stable <= w_stable_next;
            r_ext    <= w_ext_next;
            r_wrap   <= w_wrap && !src_clear;
            if (src_clear) begin
                r_ovf <= 1'b0;
            end else if (w_wrap && (&r_ext)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Snapshot FSM: arm on request, capture once the value is stable, hold
    // until the reader takes it. Requests outside IDLE are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_snap_count <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (snap_req) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_capture) begin
                        r_snap_count <= w_capture_value;
                        r_snap_valid <= 1'b1;
                        r_state      <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (snap_ready) begin
                        r_snap_valid <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_snap_valid <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef RIPPLE_EXT_DELTA_EN
    logic [c_TW-1:0] r_prev_snap;
    logic [c_TW-1:0] r_delta;

    // Delta against the previous capture; a clear restarts from zero so the
    // next snapshot reports its full count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_snap <= '0;
            r_delta     <= '0;
        end else if (w_capture) begin
            r_delta     <= w_capture_value - r_prev_snap;
            r_prev_snap <= w_capture_value;
        end else if (src_clear) begin
            r_prev_snap <= '0;
        end
    end

    assign snap_delta = r_delta;
`endif

    assign snap_valid   = r_snap_valid;
    assign snap_count   = r_snap_count;
    assign wrap_pulse   = r_wrap;
    assign ext_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_extender.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_extender
// Description : Self-checking bench for ripple_count_extender. Expected
//               snapshots are queued when requested and popped on snap_valid.
//               Optional feature macro: RIPPLE_EXT_DELTA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_extender;

    localparam int c_STABLE = 2;

    logic        clk;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        src_clear;
    logic        snap_req;
    logic        snap_valid;
    logic        snap_ready;
    logic [15:0] snap_count;
    logic        wrap_pulse;
    logic        ext_overflow;
`ifdef RIPPLE_EXT_DELTA_EN
    logic [15:0] snap_delta;
`endif

    ripple_count_extender #(
        .IN_WIDTH      (4),
        .EXT_WIDTH     (12),
        .STABLE_CYCLES (c_STABLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt_in       (cnt_in),
        .src_clear    (src_clear),
        .snap_req     (snap_req),
        .snap_valid   (snap_valid),
        .snap_ready   (snap_ready),
        .snap_count   (snap_count),
        .wrap_pulse   (wrap_pulse),
        .ext_overflow (ext_overflow)
`ifdef RIPPLE_EXT_DELTA_EN
        ,
        .snap_delta   (snap_delta)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] count;
        logic [15:0] delta;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   wrap_seen = 0;

    // Reference model of the tracked count.
    logic [11:0] m_ext;
    logic [3:0]  m_stable;
    logic        m_ovf;
    logic [15:0] m_prev_snap;

    // Count every wrap pulse the DUT emits.
    always @(posedge clk) begin
        if (wrap_pulse === 1'b1) wrap_seen <= wrap_seen + 1;
    end

    task automatic model_reset();
        m_ext = '0; m_stable = '0; m_ovf = 1'b0; m_prev_snap = '0;
    endtask

    task automatic model_accept(input logic [3:0] v);
        if (v != m_stable) begin
            if (v < m_stable) begin
                if (m_ext == 12'hFFF) m_ovf = 1'b1;
                m_ext = m_ext + 12'd1;
            end
            m_stable = v;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.count     = {m_ext, m_stable};
        e.delta     = e.count - m_prev_snap;
        m_prev_snap = e.count;
        sb_q.push_back(e);
    endtask

    task automatic settle(input logic [3:0] v, input int cyc);
        cnt_in = v;
        repeat (cyc) @(posedge clk);
        #1;
        model_accept(v);
    endtask

    task automatic request_and_wait(output bit got);
        got = 1'b0;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (snap_valid === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic release_snap();
        snap_ready = 1'b1;
        @(posedge clk); #1;
        snap_ready = 1'b0;
    endtask

    task automatic do_clear();
        src_clear = 1'b1;
        @(posedge clk); #1;
        src_clear = 1'b0;
        model_reset();
        settle(cnt_in, 6);
    endtask

    task automatic test_reset();
        exp_t e; bit got; int base;
        reset = 1'b1; cnt_in = 4'hA; src_clear = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", snap_valid); end
        n_cmp++; if (snap_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", snap_count); end
        n_cmp++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap_pulse); end
        n_cmp++; if (ext_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ext_overflow); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== 16'h0) begin n_fail++; $display("FAIL reset_delta: got %h expected 0000", snap_delta); end
`endif
        reset = 1'b0;
        model_reset();
        base = wrap_seen;
        settle(4'hA, 2 + c_STABLE + 2);
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got) begin n_fail++; $display("FAIL reset_snap_timeout: got no valid expected valid"); end
        n_cmp++; if (snap_count !== e.count) begin n_fail++; $display("FAIL reset_snap_count: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== e.delta) begin n_fail++; $display("FAIL reset_snap_delta: got %h expected %h", snap_delta, e.delta); end
`endif
        release_snap();
        n_cmp++; if (wrap_seen != base) begin n_fail++; $display("FAIL reset_no_wrap: got %0d pulses expected 0", wrap_seen - base); end
    endtask

    task automatic test_glitch();
        exp_t e; bit got; int base;
        settle(4'h7, 6);
        base = wrap_seen;
        cnt_in = 4'hF;
        @(posedge clk); #1;
        settle(4'h8, 6);
        n_cmp++; if (wrap_seen != base) begin n_fail++; $display("FAIL glitch_no_wrap: got %0d pulses expected 0", wrap_seen - base); end
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== e.count) begin n_fail++; $display("FAIL glitch_snap_count: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== e.delta) begin n_fail++; $display("FAIL glitch_snap_delta: got %h expected %h", snap_delta, e.delta); end
`endif
        release_snap();
    endtask

    task automatic test_wrap();
        exp_t e; bit got; int base;
        do_clear();
        base = wrap_seen;
        settle(4'hE, 6);
        settle(4'hF, 6);
        settle(4'h0, 6);
        settle(4'h1, 6);
        n_cmp++; if (wrap_seen - base != 1) begin n_fail++; $display("FAIL wrap_pulses: got %0d expected 1", wrap_seen - base); end
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== 16'h0011) begin n_fail++; $display("FAIL wrap_snap_fixed: got %h expected 0011", snap_count); end
        n_cmp++; if (snap_count !== e.count) begin n_fail++; $display("FAIL wrap_snap_model: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== e.delta) begin n_fail++; $display("FAIL wrap_snap_delta: got %h expected %h", snap_delta, e.delta); end
`endif
        release_snap();
    endtask

    task automatic test_handshake();
        exp_t e; bit got;
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== e.count) begin n_fail++; $display("FAIL hs_snap_count: got %h expected %h", snap_count, e.count); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) cnt_in = 4'h5;
            snap_req = (i == 2);
            @(posedge clk); #1;
            n_cmp++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid_hold[%0d]: got %b expected 1", i, snap_valid); end
            n_cmp++; if (snap_count !== e.count) begin n_fail++; $display("FAIL hs_count_frozen[%0d]: got %h expected %h", i, snap_count, e.count); end
        end
        snap_req = 1'b0;
        model_accept(4'h5);
        release_snap();
        n_cmp++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL hs_valid_drop: got %b expected 0", snap_valid); end
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL hs_req_ignored: got %b expected 0", snap_valid); end
        n_cmp++; if (snap_count !== e.count) begin n_fail++; $display("FAIL hs_count_held: got %h expected %h", snap_count, e.count); end
    endtask

    task automatic test_coincidence();
        exp_t e; bit got; int base;
        do_clear();
        for (int k = 0; k < 3; k++) begin
            settle(4'h8, 6);
            settle(4'h0, 6);
        end
        settle(4'hC, 6);
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== 16'h003C) begin n_fail++; $display("FAIL coin_pre_snap: got %h expected 003C", snap_count); end
        release_snap();
        settle(4'hF, 6);
        base = wrap_seen;
        // Arm the FSM so WAIT opens while the new value is still settling.
        cnt_in = 4'h0;
        model_accept(4'h0);
        push_expect();
        @(posedge clk); #1;
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== 16'h0040) begin n_fail++; $display("FAIL coin_snap_count: got %h expected 0040", snap_count); end
        n_cmp++; if (snap_count !== e.count) begin n_fail++; $display("FAIL coin_snap_model: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== 16'h0004) begin n_fail++; $display("FAIL coin_snap_delta: got %h expected 0004", snap_delta); end
`endif
        release_snap();
        n_cmp++; if (wrap_seen - base != 1) begin n_fail++; $display("FAIL coin_wrap: got %0d pulses expected 1", wrap_seen - base); end
    endtask

    task automatic test_mid_reset();
        bit got;
        request_and_wait(got);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (!got || snap_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", snap_valid); end
        n_cmp++; if (snap_count !== 16'h0) begin n_fail++; $display("FAIL midreset_count: got %h expected 0000", snap_count); end
        reset = 1'b0;
        model_reset();
        settle(cnt_in, 6);
    endtask

    task automatic test_overflow();
        exp_t e; bit got; int base;
        base = wrap_seen;
        for (int i = 0; i < 4096; i++) begin
            settle(4'h8, 5);
            settle(4'h0, 5);
            if (i == 4094) begin
                n_cmp++; if (ext_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ext_overflow); end
            end
        end
        n_cmp++; if (wrap_seen - base != 4096) begin n_fail++; $display("FAIL ovf_wraps: got %0d expected 4096", wrap_seen - base); end
        n_cmp++; if (ext_overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_set: got %b expected %b", ext_overflow, m_ovf); end
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== e.count) begin n_fail++; $display("FAIL ovf_snap_count: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== e.delta) begin n_fail++; $display("FAIL ovf_snap_delta: got %h expected %h", snap_delta, e.delta); end
`endif
        release_snap();
        repeat (10) @(posedge clk); #1;
        n_cmp++; if (ext_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ext_overflow); end
        do_clear();
        n_cmp++; if (ext_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ext_overflow); end
        push_expect();
        request_and_wait(got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || snap_count !== 16'h0000 || snap_count !== e.count) begin n_fail++; $display("FAIL ovf_clear_snap: got %h expected %h", snap_count, e.count); end
`ifdef RIPPLE_EXT_DELTA_EN
        n_cmp++; if (snap_delta !== e.delta) begin n_fail++; $display("FAIL ovf_clear_delta: got %h expected %h", snap_delta, e.delta); end
`endif
        release_snap();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wrap();
        test_handshake();
        test_coincidence();
        test_mid_reset();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ripple_count_extender.md
Name: ripple_count_extender

Overview:
- Downstream consumer of the 4-bit ripple-carry counter output.
- Samples the asynchronous, glitch-prone ripple count into the system clock domain and filters out ripple transients.
- Extends the count with a wrap-tracking high part.
- Returns full-width snapshots over a valid/ready handshake to a host-side reader.

Parameters:
IN_WIDTH, 4, width of the ripple counter bus being sampled
EXT_WIDTH, 12, width of the extension (wrap) counter
STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (min 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  reset, synchronous, active-high
cnt_in  input  IN_WIDTH  raw ripple counter output, asynchronous to clk
src_clear  input  1  high when the source counter is being reset; clears tracking without counting a wrap
snap_req  input  1  single-cycle request for a snapshot
snap_valid  output  1  snapshot available
snap_ready  input  1  consumer accepts snapshot
snap_count  output  IN_WIDTH+EXT_WIDTH  {ext, stable low bits}
wrap_pulse  output  1  one-cycle pulse on each accepted wrap
ext_overflow  output  1  sticky; extension counter wrapped past all-ones

Behaviour:
- Reset: all outputs 0; synchronizer, filter, stable value, ext, FSM (IDLE) and sticky flag cleared.
- Sync stage:
  - Each cnt_in bit passes through a 2-flop synchronizer.
  - The synchronized bus may be momentarily incoherent.
- Stability filter:
  - Run counter increments while the synchronized value equals the previous sample; reloads to 1 on change.
  - Value is accepted (accept=1 for one cycle) when the run reaches STABLE_CYCLES and the value differs from stable_q.
  - Run saturates; no repeat accepts for an unchanged value.
  - Latency from cnt_in change to stable_q update: 2 + STABLE_CYCLES clk cycles.
- Wrap detection:
  - On accept with new < stable_q, ext increments and wrap_pulse=1 in the same cycle stable_q updates.
  - The source must not advance 2^IN_WIDTH or more steps between accepts; this is a documented constraint and is not checked.
- Overflow: ext at all-ones plus a wrap gives ext=0 and sets ext_overflow, which stays set until reset or src_clear.
- src_clear:
  - Has priority over accept.
  - Clears ext, stable_q, run counter and ext_overflow; no wrap_pulse.
  - The FSM is unaffected, except that a HOLD snapshot is kept intact.
- Snapshot FSM:
  - IDLE: snap_req=1 -> WAIT.
  - WAIT: first cycle with run >= STABLE_CYCLES (current value stable, whether newly accepted or not) -> capture {ext_next, stable_next} into snap_count -> HOLD. If a wrap is accepted in the capture cycle, the post-wrap value is captured.
  - HOLD: snap_valid=1, snap_count frozen. snap_valid && snap_ready -> IDLE, snap_valid=0 next cycle.
- snap_req in WAIT or HOLD is ignored; no queuing.
- snap_count holds its last value after handshake.
- Reset mid-operation returns to IDLE in one cycle and drops snap_valid.

Optional Feature:
- Macro: RIPPLE_EXT_DELTA_EN.
- With the macro defined:
  - Adds output snap_delta [IN_WIDTH+EXT_WIDTH-1:0] = captured count minus the previously captured count, modulo 2^(IN_WIDTH+EXT_WIDTH).
  - snap_delta is valid with snap_valid.
  - The first snapshot after reset or src_clear reports delta = snap_count.
- Without the macro: port and previous-snapshot register absent; all other behaviour identical.

Decomposition:
- Package ripple_ext_pkg:
  - FSM state enum: IDLE, WAIT, HOLD.
  - Localparam helpers for total width (IN_WIDTH+EXT_WIDTH).
  - Run-counter width, computed by clog2 of STABLE_CYCLES+1.
- One sub-module: sync_2ff (single-bit two-flop synchronizer, reset to 0), instantiated IN_WIDTH times.

Test Plan:
- Reset: hold reset 3 cycles with cnt_in=4'hA -> all outputs 0, FSM IDLE; after release, stable_q=4'hA after 2+STABLE_CYCLES cycles with no wrap_pulse.
- Glitch rejection: cnt_in 4'h7 -> 4'hF for 1 clk -> 4'h8, then held -> 4'hF never accepted; 4'h8 accepted; no wrap_pulse.
- Wrap: step cnt_in 4'hE, 4'hF, 4'h0, 4'h1, each held 6 cycles -> exactly one wrap_pulse on 4'h0 accept; snapshot afterwards returns 12'h001_1 (snap_count=16'h0011).
- Overflow: preload via 4096 wraps -> ext=0, ext_overflow=1 stays set; src_clear pulse -> ext_overflow=0, snapshot=0.
- Handshake: snap_req with snap_ready=0 for 5 cycles -> snap_valid high and snap_count constant throughout; second snap_req during HOLD ignored; snap_ready=1 -> snap_valid low the following cycle.
- Capture/wrap coincidence and delta: snap_req issued so WAIT coincides with accept of 4'h0 after 4'hF (ext 3 -> 4) -> snap_count=16'h0040. With RIPPLE_EXT_DELTA_EN and previous snapshot 16'h003C: snap_delta=16'h0004.
